// File: rtl/wb_regfile_writer.sv
// Write-back stage: a small request FIFO feeding a 16 x 64-bit register file.
// 8/16-bit writes merge into the old value and 32-bit writes zero-extend.
// A busy scoreboard tracks destinations whose producer has not yet committed.
module wb_regfile_writer #(
  parameter int NREGS  = 16,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wb_valid,
  output logic                           wb_ready,
  input  logic [3:0]                     wb_dstreg,
  input  logic [1:0]                     wb_size,
  input  logic [DATA_W-1:0]              wb_data,
  input  logic                           wb_nop,
  output logic [NREGS-1:0][DATA_W-1:0]   regx_out,
  input  logic                           iss_valid,
  input  logic [3:0]                     iss_dstreg,
  output logic [NREGS-1:0]               busy,
  output logic                           commit_valid,
  output logic [3:0]                     commit_reg
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic              nop;
    logic [3:0]        dst;
    logic [1:0]        size;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             fifo_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ready_q, ready_d;
  logic [NREGS-1:0]   busy_q, busy_d;
  logic               commit_valid_q;
  logic [3:0]         commit_reg_q;
  logic [DATA_W-1:0]  regs_q [NREGS];

  logic               push, pop, commit_en;
  entry_t             in_entry, head;
  logic [DATA_W-1:0]  merged;

  assign in_entry  = '{nop: wb_nop, dst: wb_dstreg, size: wb_size, data: wb_data};
  assign push      = wb_valid && ready_q;
  assign pop       = (count_q != '0);
  assign head      = fifo_q[rd_ptr_q];
  assign commit_en = pop && !head.nop;

  assign wb_ready     = ready_q;
  assign busy         = busy_q;
  assign commit_valid = commit_valid_q;
  assign commit_reg   = commit_reg_q;

  // FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= in_entry;
    end
  end

  // Occupancy next-state; ready is precomputed so it never depends on wb_valid combinationally.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d < DEPTH_C);
  end

  // Partial-write merge of the head entry against the current register value.
  always_comb begin
    merged = regs_q[head.dst];
    case (head.size)
      2'b00:   merged[7:0]  = head.data[7:0];
      2'b01:   merged[15:0] = head.data[15:0];
      2'b10:   merged       = {{(DATA_W-32){1'b0}}, head.data[31:0]};
      default: merged       = head.data;
    endcase
  end

  // Scoreboard next-state: commit clears first, then issue sets, so set wins on a collision.
  always_comb begin
    busy_d = busy_q;
    if (commit_en) begin
      busy_d[head.dst] = 1'b0;
    end
    if (iss_valid) begin
      busy_d[iss_dstreg] = 1'b1;
    end
  end

  // Control state: FIFO pointers, occupancy, ready, scoreboard and commit report.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      ready_q        <= 1'b0;
      busy_q         <= '0;
      commit_valid_q <= 1'b0;
      commit_reg_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q        <= count_d;
      ready_q        <= ready_d;
      busy_q         <= busy_d;
      commit_valid_q <= commit_en;
      if (commit_en) begin
        commit_reg_q <= head.dst;
      end
    end
  end

  // One write port per register; only the register named by the committing head updates.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        regs_q[gi] <= '0;
      end else if (commit_en && (head.dst == 4'(gi))) begin
        regs_q[gi] <= merged;
      end
    end
    assign regx_out[gi] = regs_q[gi];
  end

endmodule

// File: tb/tb_wb_regfile_writer.sv
// Bench for wb_regfile_writer: directed vector table, hand sequences for
// back-to-back, scoreboard collision and mid-cycle reset, then random traffic
// checked every cycle against a request-queue reference model.
module tb_wb_regfile_writer;
  localparam int DEPTH = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              wb_valid;
  logic              wb_ready;
  logic [3:0]        wb_dstreg;
  logic [1:0]        wb_size;
  logic [63:0]       wb_data;
  logic              wb_nop;
  logic [15:0][63:0] regx_out;
  logic              iss_valid;
  logic [3:0]        iss_dstreg;
  logic [15:0]       busy;
  logic              commit_valid;
  logic [3:0]        commit_reg;

  always #5 clk = ~clk;

  wb_regfile_writer #(.NREGS(16), .DATA_W(64), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dstreg(wb_dstreg),
    .wb_size(wb_size), .wb_data(wb_data), .wb_nop(wb_nop),
    .regx_out(regx_out), .iss_valid(iss_valid), .iss_dstreg(iss_dstreg),
    .busy(busy), .commit_valid(commit_valid), .commit_reg(commit_reg)
  );

  typedef struct {
    logic [3:0]  dst;
    logic [1:0]  size;
    logic [63:0] data;
    logic        nop;
  } req_t;

  // reference model state
  req_t        q[$];
  logic [63:0] m_regs [16];
  logic [15:0] m_busy;
  logic        m_cv;
  logic [3:0]  m_cr;
  logic        m_ready;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // New register value from the size rules: bytes kept from old, bytes taken from data.
  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] data,
                                        input logic [1:0] size);
    logic [63:0] take;
    logic [63:0] keep;
    case (size)
      2'd0:    begin take = 64'hFF;         keep = ~64'hFF;   end
      2'd1:    begin take = 64'hFFFF;       keep = ~64'hFFFF; end
      2'd2:    begin take = 64'hFFFF_FFFF;  keep = 64'h0;     end
      default: begin take = ~64'h0;         keep = 64'h0;     end
    endcase
    return (old & keep) | (data & take);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 64'h0;
    m_busy  = 16'h0;
    m_cv    = 1'b0;
    m_cr    = 4'h0;
    m_ready = 1'b0;
    q.delete();
  endtask

  // One rising edge of the spec: oldest queued request retires, issue marks busy, new request enqueues.
  task automatic model_edge();
    req_t r;
    logic accepted;
    accepted = wb_valid && m_ready;
    m_cv = 1'b0;
    if (q.size() > 0) begin
      r = q.pop_front();
      if (!r.nop) begin
        m_regs[r.dst] = merge(m_regs[r.dst], r.data, r.size);
        m_busy[r.dst] = 1'b0;
        m_cv = 1'b1;
        m_cr = r.dst;
      end
    end
    if (iss_valid) m_busy[iss_dstreg] = 1'b1;
    if (accepted) begin
      r.dst = wb_dstreg; r.size = wb_size; r.data = wb_data; r.nop = wb_nop;
      q.push_back(r);
    end
    m_ready = (q.size() < DEPTH);
  endtask

  task automatic check_all();
    for (int i = 0; i < 16; i++) chk($sformatf("model_reg%0d", i), regx_out[i], m_regs[i]);
    chk("model_busy", 64'(busy), 64'(m_busy));
    chk("model_commit_valid", 64'(commit_valid), 64'(m_cv));
    chk("model_commit_reg", 64'(commit_reg), 64'(m_cr));
    chk("model_wb_ready", 64'(wb_ready), 64'(m_ready));
  endtask

  task automatic step(input logic v, input logic [3:0] dst, input logic [1:0] size,
                      input logic [63:0] data, input logic nop,
                      input logic iv, input logic [3:0] id);
    wb_valid = v; wb_dstreg = dst; wb_size = size; wb_data = data; wb_nop = nop;
    iss_valid = iv; iss_dstreg = id;
    @(posedge clk);
    if (reset) model_edge();
    else       model_reset();
    #1;
    check_all();
    $display("t=%0t rst_n=%0b v=%0b rdy=%0b dst=%0d sz=%0d nop=%0b data=%h iss=%0b/%0d -> cv=%0b cr=%0d busy=%h",
             $time, reset, v, wb_ready, dst, size, nop, data, iv, id, commit_valid, commit_reg, busy);
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 2'd0, 64'h0, 1'b0, 1'b0, 4'd0);
  endtask

  typedef struct {
    logic [3:0]  dst;
    logic [1:0]  size;
    logic [63:0] data;
    logic        nop;
    logic        iv;
    logic [3:0]  id;
    logic [3:0]  chk_reg;
    logic [63:0] exp_val;
    logic        exp_cv;
    logic [3:0]  exp_cr;
    logic [15:0] exp_busy;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{4'd0, 2'd3, 64'h1122334455667788, 1'b0, 1'b0, 4'd0, 4'd0, 64'h1122334455667788, 1'b1, 4'd0, 16'h0000};
    vecs[1] = '{4'd3, 2'd3, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 4'd0, 4'd3, 64'hFFFFFFFFFFFFFFFF, 1'b1, 4'd3, 16'h0000};
    vecs[2] = '{4'd3, 2'd0, 64'h0123456789ABCDAB, 1'b0, 1'b0, 4'd0, 4'd3, 64'hFFFFFFFFFFFFFFAB, 1'b1, 4'd3, 16'h0000};
    vecs[3] = '{4'd3, 2'd1, 64'hAAAABBBBCCCC1234, 1'b0, 1'b0, 4'd0, 4'd3, 64'hFFFFFFFFFFFF1234, 1'b1, 4'd3, 16'h0000};
    vecs[4] = '{4'd3, 2'd2, 64'h99998888DEADBEEF, 1'b0, 1'b0, 4'd0, 4'd3, 64'h00000000DEADBEEF, 1'b1, 4'd3, 16'h0000};
    vecs[5] = '{4'd4, 2'd3, 64'hCAFEF00D12345678, 1'b0, 1'b0, 4'd0, 4'd4, 64'hCAFEF00D12345678, 1'b1, 4'd4, 16'h0000};
    vecs[6] = '{4'd7, 2'd3, 64'h0000000000000055, 1'b1, 1'b1, 4'd7, 4'd7, 64'h0000000000000000, 1'b0, 4'd4, 16'h0080};
    vecs[7] = '{4'd7, 2'd3, 64'h0000000000000001, 1'b0, 1'b0, 4'd0, 4'd7, 64'h0000000000000001, 1'b1, 4'd7, 16'h0000};

    reset = 1'b0;
    wb_valid = 1'b0; wb_dstreg = 4'd0; wb_size = 2'd0; wb_data = 64'h0; wb_nop = 1'b0;
    iss_valid = 1'b0; iss_dstreg = 4'd0;
    model_reset();

    // held in reset: everything zero, not ready
    idle();
    idle();
    chk("rst_ready", 64'(wb_ready), 64'h0);
    chk("rst_commit_valid", 64'(commit_valid), 64'h0);
    #3 reset = 1'b1;
    idle();
    chk("ready_after_release", 64'(wb_ready), 64'h1);

    // directed vector table: push then one idle edge to commit
    for (int i = 0; i < 8; i++) begin
      step(1'b1, vecs[i].dst, vecs[i].size, vecs[i].data, vecs[i].nop, vecs[i].iv, vecs[i].id);
      idle();
      chk($sformatf("tbl%0d_reg", i), regx_out[vecs[i].chk_reg], vecs[i].exp_val);
      chk($sformatf("tbl%0d_cv", i), 64'(commit_valid), 64'(vecs[i].exp_cv));
      chk($sformatf("tbl%0d_cr", i), 64'(commit_reg), 64'(vecs[i].exp_cr));
      chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(vecs[i].exp_busy));
    end

    // back-to-back pushes to 1, 2, 3
    step(1'b1, 4'd1, 2'd3, 64'h1111, 1'b0, 1'b0, 4'd0);
    chk("b2b_ready0", 64'(wb_ready), 64'h1);
    step(1'b1, 4'd2, 2'd3, 64'h2222, 1'b0, 1'b0, 4'd0);
    chk("b2b_ready1", 64'(wb_ready), 64'h1);
    chk("b2b_c1", {63'h0, commit_valid} << 4 | 64'(commit_reg), 64'h11);
    step(1'b1, 4'd3, 2'd3, 64'h3333, 1'b0, 1'b0, 4'd0);
    chk("b2b_ready2", 64'(wb_ready), 64'h1);
    chk("b2b_c2", {63'h0, commit_valid} << 4 | 64'(commit_reg), 64'h12);
    idle();
    chk("b2b_c3", {63'h0, commit_valid} << 4 | 64'(commit_reg), 64'h13);
    chk("b2b_reg2", regx_out[2], 64'h2222);

    // scoreboard set/clear collision on reg 5
    step(1'b0, 4'd0, 2'd0, 64'h0, 1'b0, 1'b1, 4'd5);
    chk("sb_set", 64'(busy[5]), 64'h1);
    step(1'b1, 4'd5, 2'd3, 64'h5555, 1'b0, 1'b0, 4'd0);
    step(1'b0, 4'd0, 2'd0, 64'h0, 1'b0, 1'b1, 4'd5);
    chk("sb_collide_busy", 64'(busy[5]), 64'h1);
    chk("sb_collide_cr", 64'(commit_reg), 64'h5);
    step(1'b1, 4'd5, 2'd0, 64'hFFFF_FFFF_FFFF_FF77, 1'b0, 1'b0, 4'd0);
    idle();
    chk("sb_clear_busy", 64'(busy[5]), 64'h0);
    chk("sb_reg5", regx_out[5], 64'h5577);

    // mid-cycle reset with one committed and one pending entry
    step(1'b1, 4'd9, 2'd3, 64'hAAAA_0000_0000_0009, 1'b0, 1'b1, 4'd12);
    step(1'b1, 4'd10, 2'd3, 64'hBBBB_0000_0000_0010, 1'b0, 1'b0, 4'd0);
    chk("mid_reg9_before", regx_out[9], 64'hAAAA_0000_0000_0009);
    #3 reset = 1'b0;
    #1;
    model_reset();
    chk("mid_reg9", regx_out[9], 64'h0);
    chk("mid_busy", 64'(busy), 64'h0);
    chk("mid_ready", 64'(wb_ready), 64'h0);
    chk("mid_cv", 64'(commit_valid), 64'h0);
    idle();
    #3 reset = 1'b1;
    idle();
    chk("post_cv", 64'(commit_valid), 64'h0);
    chk("post_reg10", regx_out[10], 64'h0);
    chk("post_ready", 64'(wb_ready), 64'h1);
    idle();
    chk("post_cv2", 64'(commit_valid), 64'h0);
    chk("post_reg10_2", regx_out[10], 64'h0);

    // random traffic against the model
    for (int n = 0; n < 300; n++) begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      step(($urandom_range(9) < 7), 4'($urandom_range(15)), 2'($urandom_range(3)), d,
           ($urandom_range(9) == 0), ($urandom_range(9) < 3), 4'($urandom_range(15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
